sm: RTL and testbench
=====================

Name: sm

Overview:
- Phase-generator state machine for the pipelined CPU.
- After a `start` request it drives a one-hot 4-phase clock-enable vector `q`, rotating one phase per clock.
- After a `stop` request it finishes the current 4-phase cycle, then parks idle with `q` = 0.
- Sits beside the pipeline control; each stage qualifies its register updates with its phase bit.

Parameters:
- NPH, 4, number of phases; width of `q`. Only 4 is required; RTL must stay generic in NPH ≥ 2.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RSTN  input  1  asynchronous active-low reset.
- start  input  1  level request to begin phase rotation; sampled on rising CLK.
- stop  input  1  level request to halt after the current cycle; sampled on rising CLK.
- q  output  NPH  one-hot phase vector; all zeros when idle.

Behaviour:
- Reset (RSTN = 0, asynchronous): state IDLE, `q` = 0000, stop-pending flag cleared. State holds while RSTN is low.
- States: IDLE and RUN. A registered flag `stop_pend` is held alongside the state.
- `q` is a direct register output with no combinational path from the inputs.
- IDLE transitions:
  - start = 1 and stop = 0 at a rising edge: go to RUN, `q` = 0001 in the next cycle (1-cycle latency).
  - start = 1 and stop = 1 together: stop wins; remain IDLE, `q` = 0000.
  - Otherwise remain IDLE.
- RUN rotation: each rising edge moves `q` from 0001 to 0010 to 0100 to 1000 and wraps back to 0001. Exactly one bit is set in every RUN cycle.
- Stop request: stop = 1 sampled in RUN sets `stop_pend`. Stop is a level input, so a one-cycle pulse is sufficient.
- Stop completion: when `q` = 1000 and (`stop_pend` or stop = 1), the next state is IDLE, `q` = 0000, `stop_pend` cleared. The cycle in progress always completes; no partial cycle is ever issued.
- Stop in the final phase: stop first seen while `q` = 1000 halts at that same edge.
- start while in RUN is ignored, including when `stop_pend` is set; it does not cancel a pending stop.
- start held high continuously gives continuous rotation. After a stop completes, start still high restarts only if stop is low: IDLE-to-RUN transition on the following edge.
- Reset mid-RUN: immediate return to IDLE, `q` = 0000, regardless of phase.
- No X propagation: unknown inputs during reset have no effect.

Decomposition:
- Shared package `sm_pkg`: state enum (IDLE, RUN), NPH default, phase constants PH0..PH3 (one-hot 0001..1000).
- No sub-module.
- The rotate-left one-hot register and the `stop_pend` flag are simple enough to stay inline.

Test Plan:
- Reset: RSTN = 0 for 5 cycles with start/stop toggling -> `q` = 0000 throughout; release -> still 0000 until start.
- Start: start = 1 for 4 cycles after reset -> `q` = 0001, 0010, 0100, 1000 on successive cycles, first one-hot value 1 cycle after start is sampled. Then wraps to 0001 and continues after start drops.
- Stop mid-cycle: stop pulsed 1 cycle while `q` = 0010 -> `q` goes 0100, 1000, then 0000 and stays 0000.
- Stop in final phase: stop sampled while `q` = 1000 -> `q` = 0000 next cycle. Stop held for 5 cycles -> remains idle; start = 1 with stop = 0 -> restart at 0001.
- Simultaneous start and stop in IDLE -> `q` stays 0000. Start asserted while running with stop pending -> halts at end of cycle anyway.
- Asynchronous reset at `q` = 0100 mid-clock -> `q` = 0000 immediately, before the next edge.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared types and constants for the phase-generator state machine.
// Holds the state encoding, default phase count and one-hot phase values.
package sm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NPH_DEF = 4;

  localparam logic [3:0] PH0 = 4'b0001;
  localparam logic [3:0] PH1 = 4'b0010;
  localparam logic [3:0] PH2 = 4'b0100;
  localparam logic [3:0] PH3 = 4'b1000;

endpackage

// File: rtl/sm.sv
// Phase generator: rotates a one-hot clock-enable vector while running and
// always completes the current phase cycle before parking idle on stop.
module sm
  import sm_pkg::*;
#(
  parameter int NPH = NPH_DEF
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           start,
  input  logic           stop,
  output logic [NPH-1:0] q
);

  state_e         state_q, state_d;
  logic [NPH-1:0] q_q, q_d;
  logic           stop_pend_q, stop_pend_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      q_q         <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        q_d         = '0;
        stop_pend_d = 1'b0;
        // A simultaneous stop overrides start.
        if (start && !stop) begin
          state_d = RUN;
          q_d[0]  = 1'b1;
        end
      end
      RUN: begin
        // Only the last phase may end a cycle; earlier stops are remembered.
        if (q_q[NPH-1] && (stop_pend_q || stop)) begin
          state_d     = IDLE;
          q_d         = '0;
          stop_pend_d = 1'b0;
        end else begin
          q_d = {q_q[NPH-2:0], q_q[NPH-1]};
          if (stop) stop_pend_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        q_d         = '0;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  assign q = q_q;

endmodule

// File: tb/tb_sm.sv
// Directed bench for the phase generator: reset, rotation, stop handling,
// start/stop priority and asynchronous reset in the middle of a cycle.
module tb_sm;
  import sm_pkg::*;

  localparam int NPH = 4;

  logic           CLK;
  logic           RSTN;
  logic           start;
  logic           stop;
  logic [NPH-1:0] q;

  int ncmp;
  int nerr;

  sm #(.NPH(NPH)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .start(start),
    .stop (stop),
    .q    (q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [NPH-1:0] exp);
    ncmp++;
    assert (q === exp)
    else begin
      nerr++;
      $error("FAIL %s: q=%b expected %b", tag, q, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ncmp  = 0;
    nerr  = 0;
    RSTN  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;

    // Reset held with inputs toggling
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      stop  = i[1];
      step();
      check("reset_hold", 4'b0000);
    end

    RSTN  = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    step(); check("post_reset0", 4'b0000);
    step(); check("post_reset1", 4'b0000);

    // Start for 4 cycles then release; rotation continues
    start = 1'b1;
    step(); check("start_ph0", PH0);
    step(); check("start_ph1", PH1);
    step(); check("start_ph2", PH2);
    step(); check("start_ph3", PH3);
    start = 1'b0;
    step(); check("wrap_ph0", PH0);
    step(); check("wrap_ph1", PH1);

    // Stop pulse while q = 0010 completes the cycle
    stop = 1'b1;
    step(); check("midstop_ph2", PH2);
    stop = 1'b0;
    step(); check("midstop_ph3", PH3);
    step(); check("midstop_idle0", 4'b0000);
    step(); check("midstop_idle1", 4'b0000);

    // Stop first seen in the final phase
    start = 1'b1;
    step(); check("run2_ph0", PH0);
    start = 1'b0;
    step(); check("run2_ph1", PH1);
    step(); check("run2_ph2", PH2);
    step(); check("run2_ph3", PH3);
    stop = 1'b1;
    step(); check("laststop_idle", 4'b0000);

    // Stop held alongside start: stop wins in IDLE
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("startstop_idle", 4'b0000);
    end
    stop = 1'b0;
    step(); check("restart_ph0", PH0);

    // Pending stop not cancelled by start in RUN
    start = 1'b0;
    stop  = 1'b1;
    step(); check("pend_ph1", PH1);
    stop  = 1'b0;
    start = 1'b1;
    step(); check("pend_ph2", PH2);
    step(); check("pend_ph3", PH3);
    step(); check("pend_idle", 4'b0000);
    step(); check("pend_restart_ph0", PH0);
    start = 1'b0;
    step(); check("ar_ph1", PH1);
    step(); check("ar_ph2", PH2);

    // Asynchronous reset between edges
    #2;
    RSTN = 1'b0;
    #1;
    check("async_reset_now", 4'b0000);
    step(); check("async_reset_hold", 4'b0000);
    RSTN = 1'b1;
    step(); check("async_reset_rel", 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
